// File: rtl/flit_demux4_mc.sv
// 1-to-4 multicast flit demultiplexer with one registered holding slot per output.
// A flit is copied into every masked slot in the same edge, or into none of them.
module flit_demux4_mc #(
    parameter int DW    = 32,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   in_data,
    input  logic [3:0]      in_mask,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [4*DW-1:0] out_data,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DW-1:0] slot_data [4];
    logic [3:0]    slot_valid;
    logic [3:0]    can_take;
    logic [3:0]    load;
    logic          accept;
    logic          drop;

    // A slot draining this cycle is free, so streaming runs without bubbles.
    assign can_take = ~slot_valid | out_ready;
    assign in_ready = &(can_take | ~in_mask);
    assign accept   = in_valid & in_ready;
    assign load     = {4{accept}} & in_mask;
    assign drop     = accept & (in_mask == 4'b0000);

    for (genvar i = 0; i < 4; i++) begin : g_slot
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                slot_valid[i] <= 1'b0;
                slot_data[i]  <= '0;
            end else if (load[i]) begin
                slot_valid[i] <= 1'b1;
                slot_data[i]  <= in_data;
            end else if (out_ready[i]) begin
                slot_valid[i] <= 1'b0;
            end
        end

        assign out_data[i*DW +: DW] = slot_data[i];
    end

    assign out_valid = slot_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: doc/flit_demux4_mc.md
Name: flit_demux4_mc

Overview:
- 1-to-4 multicast flit demultiplexer; the fan-out counterpart of the 4:1 flit select mux in the bless_mc datapath.
- Takes one flit plus a 4-bit destination mask, and delivers copies to every masked output port, all in the same cycle.
- Each output has a one-entry registered holding slot with a valid/ready handshake.
- Sits between the multicast port-allocation stage and the per-port output/link registers.

Parameters:
- DW, 32, flit data width in bits.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DW  input flit payload.
- in_mask  in  4  destination bitmap; bit i targets output i.
- in_valid  in  1  input flit present.
- in_ready  out  1  input can be accepted this cycle (combinational).
- out_data  out  4*DW  output slot payloads; slot i occupies bits [i*DW +: DW].
- out_valid  out  4  per-output slot occupied.
- out_ready  in  4  per-output downstream accept.
- drop_cnt  out  CNT_W  count of flits dropped because in_mask == 0.

Behaviour:
- Reset (async, active-high):
  - out_valid = 4'b0000, out_data = 0, drop_cnt = 0.
  - Flits held in slots at reset are discarded; no partial state survives.
- Slot i "can take" this cycle = !out_valid[i] | out_ready[i]. A slot draining in the same cycle counts as free (full throughput, no bubble).
- in_ready = AND of can-take[i] over all i with in_mask[i] = 1.
  - in_mask == 0 forces in_ready = 1.
  - in_ready is combinational from out_ready, out_valid and in_mask.
- Accept = in_valid & in_ready.
- All-or-nothing multicast:
  - On accept, every masked slot loads in_data and sets out_valid[i] = 1 at the next edge.
  - If any masked slot cannot take, no slot loads. The flit waits and the upstream holds in_data and in_mask stable.
  - A partial copy is never emitted.
- Latency: an accepted flit is visible on out_data/out_valid one cycle after acceptance.
- Unmasked slot i: if out_valid[i] & out_ready[i], clear out_valid[i]. out_data[i] holds its value; it is don't-care when out_valid[i] = 0.
- Stability: while out_valid[i] & !out_ready[i], out_data[i] and out_valid[i] must not change.
- Simultaneous drain and load on the same slot: the load wins. out_valid[i] stays 1 with the new payload, and the old flit counts as delivered.
- Ordering: per output, flits leave in acceptance order. With a single-entry slot, reordering is impossible.
- Empty mask: when in_valid & in_mask == 0, the flit is accepted and discarded; no output changes.
  - drop_cnt increments by 1 per such flit and saturates at 2^CNT_W-1 with no wrap.
- in_valid = 0: no loads. Slots drain independently per out_ready.
- No internal FSM beyond the per-slot valid bits. There are four independent two-state slots (EMPTY <-> FULL):
  - EMPTY->FULL on load.
  - FULL->EMPTY on drain without load.
  - FULL->FULL on stall, or on drain+load.

Test Plan:
- Unicast sweep: for i = 0..3, in_mask = 1<<i, in_data = 32'hA000_000i, out_ready = 4'hF -> one cycle later out_valid = 1<<i with the matching payload; in_ready stays 1 throughout; slot clears the following cycle.
- Broadcast with one stalled port: slot 2 full, out_ready = 4'b1011, in_mask = 4'hF -> in_ready = 0, no slot changes. Release out_ready[2] -> all four slots load 32'hDEAD_BEEF in the same edge.
- Back-to-back throughput: 8 flits to mask 4'b0101 with out_ready = 4'hF -> one accept per cycle, outputs 0 and 2 each see all 8 payloads in order, no bubbles.
- Stall hold: out_ready[1] = 0 for 5 cycles with slot 1 full (32'h1234_5678) -> out_data[1], out_valid[1] unchanged; a new mask 4'b0010 flit is held off (in_ready = 0) until the slot is released.
- Drop counter: 300 flits with in_mask = 0 at CNT_W = 8 -> in_ready = 1 every cycle, out_valid stays 0, drop_cnt ends at 255 (saturated).
- Async reset mid-traffic: assert reset between edges with out_valid = 4'b1111 and drop_cnt = 7 -> out_valid = 0 and drop_cnt = 0 immediately, before the next edge; normal operation resumes on the first edge after deassertion.
